// File: rtl/instr_fetch_unit.sv
// KGP-RISC fetch front end: IDLE/FETCH/EXEC/HALT sequencer, instruction register,
// immediate extension, branch resolution, carry flag and bl link write.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [5:0]  opcode,
  output logic [9:0]  functioncode,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [31:0] imm,
  input  logic [1:0]  extendType,
  input  logic        branch,
  input  logic        branchType,
  input  logic        brNotEq,
  input  logic        goToReg,
  input  logic [1:0]  flag,
  input  logic [31:0] rs_data,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_sign,
  input  logic        flags_we,
  input  logic        ex_stall,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic        halted
);

  localparam logic [5:0] BL_OPCODE = 6'b000110;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t      r_state, w_nextState;
  logic [31:0] r_pc, w_nextPc;
  logic [31:0] r_ir, w_nextIr;
  logic        r_carry, w_nextCarry;
  logic [31:0] w_pcPlus4, w_imm, w_target;
  logic        w_cond, w_taken, w_commit;

  assign w_pcPlus4 = r_pc + 32'd4;
  assign w_commit  = (r_state == EXEC) && !ex_stall;

  always_comb begin
    case (extendType)
      2'b10:   w_imm = {{6{r_ir[25]}}, r_ir[25:0]};
      2'b11:   w_imm = {16'b0, r_ir[15:0]};
      default: w_imm = {{16{r_ir[15]}}, r_ir[15:0]};
    endcase
  end

  // The carry used here is the registered one, so a bcy that also writes flags sees the old value.
  always_comb begin
    case (flag)
      2'b00:   w_cond = r_carry;
      2'b01:   w_cond = alu_zero;
      2'b10:   w_cond = alu_sign;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken  = branch & (~branchType | (w_cond ^ brNotEq));
  assign w_target = goToReg ? rs_data : (w_pcPlus4 + (w_imm << 2));

  always_comb begin
    w_nextState = r_state;
    w_nextPc    = r_pc;
    w_nextIr    = r_ir;
    w_nextCarry = r_carry;
    case (r_state)
      IDLE: begin
        if (start) w_nextState = FETCH;
      end
      FETCH: begin
        if (imem_valid) begin
          w_nextIr    = imem_rdata;
          w_nextState = EXEC;
        end
      end
      EXEC: begin
        if (!ex_stall) begin
          if (flags_we) w_nextCarry = alu_carry;
          if (r_ir[31:26] == HALT_OPCODE) begin
            w_nextState = HALT;
          end else begin
            w_nextState = FETCH;
            w_nextPc    = w_taken ? w_target : w_pcPlus4;
          end
        end
      end
      HALT: w_nextState = HALT;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= 32'b0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_pc    <= w_nextPc;
      r_ir    <= w_nextIr;
      r_carry <= w_nextCarry;
    end
  end

  assign imem_req     = (r_state == FETCH);
  assign imem_addr    = r_pc;
  assign pc           = r_pc;
  assign instr_valid  = (r_state == EXEC);
  assign halted       = (r_state == HALT);
  assign opcode       = r_ir[31:26];
  assign rs_addr      = r_ir[25:21];
  assign rt_addr      = r_ir[20:16];
  assign functioncode = r_ir[9:0];
  assign imm          = w_imm;
  assign link_we      = w_commit && (r_ir[31:26] == BL_OPCODE);
  assign link_data    = link_we ? w_pcPlus4 : 32'b0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded bench for instr_fetch_unit: expected fetch addresses are queued at
// each commit and popped when the unit raises imem_req.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, imem_req, imem_valid;
  logic [31:0] imem_addr, imem_rdata, imm, rs_data, pc, link_data;
  logic [5:0]  opcode;
  logic [9:0]  functioncode;
  logic [4:0]  rs_addr, rt_addr;
  logic [1:0]  extendType, flag;
  logic        branch, branchType, brNotEq, goToReg;
  logic        alu_carry, alu_zero, alu_sign, flags_we, ex_stall;
  logic        instr_valid, link_we, halted;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] expAddr[$];
  logic [31:0] modelPc    = 32'h0;
  logic        modelCarry = 1'b0;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .opcode(opcode), .functioncode(functioncode), .rs_addr(rs_addr), .rt_addr(rt_addr), .imm(imm),
    .extendType(extendType), .branch(branch), .branchType(branchType), .brNotEq(brNotEq),
    .goToReg(goToReg), .flag(flag), .rs_data(rs_data),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .flags_we(flags_we), .ex_stall(ex_stall),
    .instr_valid(instr_valid), .pc(pc), .link_we(link_we), .link_data(link_data), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic clear_controls();
    extendType = 2'b00; branch = 1'b0; branchType = 1'b0; brNotEq = 1'b0;
    goToReg = 1'b0; flag = 2'b00; rs_data = 32'h0; alu_carry = 1'b0;
    alu_zero = 1'b0; alu_sign = 1'b0; flags_we = 1'b0; ex_stall = 1'b0;
  endtask

  // Waits for a request, checks its address against the scoreboard, then answers it.
  task automatic fetch_word(input logic [31:0] word, input int waitCycles);
    int n = 0;
    logic [31:0] exp;
    @(negedge clk);
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (imem_req !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL fetch_req_timeout: got imem_req=%b expected 1", imem_req);
    end
    exp = (expAddr.size() > 0) ? expAddr.pop_front() : 32'hDEAD_BEEF;
    compared++;
    if (imem_addr !== exp) begin
      mismatched++;
      $display("[TB] FAIL fetch_addr: got %h expected %h", imem_addr, exp);
    end
    repeat (waitCycles) @(negedge clk);
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== exp) begin
      mismatched++;
      $display("[TB] FAIL fetch_hold: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, exp);
    end
    imem_rdata = word;
    imem_valid = 1'b1;
    @(posedge clk); #1;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
  endtask

  // Lets the EXEC cycle retire and checks the new pc; queues the next fetch address.
  task automatic commit(input string name, input logic [31:0] expPc);
    @(posedge clk); #1;
    compared++;
    if (pc !== expPc) begin
      mismatched++;
      $display("[TB] FAIL %s_pc: got %h expected %h", name, pc, expPc);
    end
    compared++;
    if (instr_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_valid_drop: got %b expected 0", name, instr_valid);
    end
    if (flags_we) modelCarry = alu_carry;
    modelPc = expPc;
    expAddr.push_back(expPc);
    clear_controls();
  endtask

  task automatic run_plain(input logic we, input logic cy);
    fetch_word(32'h0C00_0001, 1);
    flags_we  = we;
    alu_carry = cy;
    commit("plain", modelPc + 32'd4);
  endtask

  // Conditional branch with a 16-bit offset of 3 words; expTaken is supplied by the caller.
  task automatic run_cond(input string name, input logic bne, input logic [1:0] fl,
                          input logic zero, input logic we, input logic cy, input logic expTaken);
    fetch_word(32'h1C00_0003, 1);
    branch = 1'b1; branchType = 1'b1; brNotEq = bne; flag = fl;
    alu_zero = zero; flags_we = we; alu_carry = cy;
    commit(name, expTaken ? modelPc + 32'd16 : modelPc + 32'd4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; imem_valid = 1'b0; imem_rdata = 32'h0;
    clear_controls();
    repeat (2) @(negedge clk);
    compared++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0 || link_we !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: got req=%b valid=%b halted=%b link_we=%b expected all 0",
               imem_req, instr_valid, halted, link_we);
    end
    compared++;
    if (pc !== 32'h0 || imem_addr !== 32'h0 || opcode !== 6'h0 || imm !== 32'h0 || link_data !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_data: got pc=%h addr=%h op=%h imm=%h link=%h expected all 0",
               pc, imem_addr, opcode, imm, link_data);
    end
  endtask

  task automatic test_addi();
    rst_n = 1'b1;
    expAddr.push_back(32'h0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fetch_word(32'h0C00_0005, 2);
    @(negedge clk);
    compared++;
    if (opcode !== 6'b000011 || imm !== 32'd5 || functioncode !== 10'd5 || rs_addr !== 5'd0) begin
      mismatched++;
      $display("[TB] FAIL addi_fields: got op=%b imm=%h fc=%h rs=%h expected 000011 5 5 0",
               opcode, imm, functioncode, rs_addr);
    end
    compared++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL addi_exec: got valid=%b req=%b expected 1 0", instr_valid, imem_req);
    end
    commit("addi", 32'h4);
  endtask

  task automatic test_b_bl();
    run_plain(1'b0, 1'b0);
    fetch_word(32'h17FF_FFFE, 1);
    branch = 1'b1; extendType = 2'b10;
    @(negedge clk);
    compared++;
    if (imm !== 32'hFFFF_FFFE || link_we !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b_imm: got imm=%h link_we=%b expected fffffffe 0", imm, link_we);
    end
    commit("b", 32'h4);
    run_plain(1'b0, 1'b0);
    fetch_word(32'h1BFF_FFFE, 1);
    branch = 1'b1; extendType = 2'b10;
    @(negedge clk);
    compared++;
    if (link_we !== 1'b1 || link_data !== 32'd12 || opcode !== 6'b000110) begin
      mismatched++;
      $display("[TB] FAIL bl_link: got we=%b data=%h op=%b expected 1 0000000c 000110", link_we, link_data, opcode);
    end
    commit("bl", 32'h4);
  endtask

  task automatic test_cond_branch();
    run_plain(1'b1, 1'b1);
    run_cond("bcy_c1",      1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    run_cond("bncy_c1",     1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cond("bcy_old_cy",  1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    run_cond("bcy_c0",      1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cond("bncy_c0",     1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    run_cond("bz_zero",     1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
    run_cond("flag11",      1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_goToReg();
    fetch_word(32'h2000_0000, 1);
    branch = 1'b1; goToReg = 1'b1; rs_data = 32'h0000_0040;
    commit("br", 32'h40);
    fetch_word(32'h2000_0000, 1);
    branch = 1'b1; goToReg = 1'b1; rs_data = 32'h0000_0043;
    commit("br_unaligned", 32'h43);
  endtask

  task automatic test_stall();
    logic [31:0] heldPc;
    run_plain(1'b1, 1'b0);
    heldPc = modelPc;
    fetch_word(32'h1800_0004, 0);
    branch = 1'b1; extendType = 2'b10; flags_we = 1'b1; alu_carry = 1'b1; ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (instr_valid !== 1'b1 || link_we !== 1'b0 || pc !== heldPc) begin
        mismatched++;
        $display("[TB] FAIL stall_hold%0d: got valid=%b link_we=%b pc=%h expected 1 0 %h",
                 i, instr_valid, link_we, pc, heldPc);
      end
      @(posedge clk); #1;
    end
    ex_stall = 1'b0;
    @(negedge clk);
    compared++;
    if (instr_valid !== 1'b1 || link_we !== 1'b1 || link_data !== heldPc + 32'd4) begin
      mismatched++;
      $display("[TB] FAIL stall_release: got valid=%b link_we=%b data=%h expected 1 1 %h",
               instr_valid, link_we, link_data, heldPc + 32'd4);
    end
    commit("stall_bl", heldPc + 32'd20);
    run_cond("bcy_after_stall", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compared++;
    if (imem_req !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midreset: got req=%b pc=%h valid=%b expected 0 0 0", imem_req, pc, instr_valid);
    end
    expAddr.delete();
    modelPc = 32'h0;
    modelCarry = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    imem_rdata = 32'hFC00_0000;
    imem_valid = 1'b1;
    @(posedge clk); #1;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    @(negedge clk);
    compared++;
    if (opcode !== 6'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL late_valid: got op=%h req=%b valid=%b halted=%b expected 0 0 0 0",
               opcode, imem_req, instr_valid, halted);
    end
  endtask

  task automatic test_halt();
    expAddr.push_back(32'h0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fetch_word(32'hFC00_0000, 0);
    @(negedge clk);
    compared++;
    if (opcode !== 6'b111111 || instr_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL halt_decode: got op=%b valid=%b expected 111111 1", opcode, instr_valid);
    end
    @(posedge clk); #1;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      compared++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL halt_hold%0d: got halted=%b req=%b pc=%h valid=%b expected 1 0 0 0",
                 i, halted, imem_req, pc, instr_valid);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_b_bl();
    test_cond_branch();
    test_goToReg();
    test_stall();
    test_reset_mid_fetch();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
